rr_arbiter_4: RTL and testbench

- 4-requester round-robin arbiter that shares one downstream resource (e.g. a shared bus or a datapath unit) between four clients.
- Produces a registered one-hot grant, a 2-bit encoded grant index and a grant-valid flag, in the same a/y/v style as the team's 4:2 priority encoders.
- Holds a grant until the owner signals done, drops its request, or exceeds a hold limit.
- Rotating priority guarantees no starvation.

---
 rtl/rr_arbiter_4_if.sv | 13 +
 rtl/rr_arbiter_4.sv | 105 ++++++++++
 tb/tb_rr_arbiter_4.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle shared by the four clients and the round-robin arbiter.
// The master side drives requests; the slave side is the arbiter.
interface rr_arbiter_4_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    modport master (output req, done, input gnt, gnt_id, gnt_valid, timeout);
    modport slave  (input req, done, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-client round-robin arbiter. A grant is registered and held until the owner
// finishes, drops its request, or reaches the MAX_HOLD cycle limit.
//
//   state | meaning
//   IDLE  | no grant; a nonzero req is granted on the next edge
//   GRANT | gnt_id owns the resource; release on done, dropped req or hold limit
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8
) (
    input logic           clk,
    input logic           rst_n,
    rr_arbiter_4_if.slave arb
);
    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, nxt_state;
    logic [3:0]    gnt_q, nxt_gnt;
    logic [1:0]    gnt_id_q, nxt_gnt_id;
    logic [1:0]    ptr_q, nxt_ptr;
    logic [CW-1:0] hold_q, nxt_hold;
    logic          timeout_q, nxt_timeout;

    logic          win_found;
    logic [1:0]    win_id;
    logic [1:0]    idx;
    logic          owner_req;
    logic          hold_last;
    logic          release_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_q     <= 4'b0000;
            gnt_id_q  <= 2'd0;
            ptr_q     <= 2'd0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= nxt_state;
            gnt_q     <= nxt_gnt;
            gnt_id_q  <= nxt_gnt_id;
            ptr_q     <= nxt_ptr;
            hold_q    <= nxt_hold;
            timeout_q <= nxt_timeout;
        end
    end

    always_comb begin
        nxt_state   = state;
        nxt_gnt     = gnt_q;
        nxt_gnt_id  = gnt_id_q;
        nxt_ptr     = ptr_q;
        nxt_hold    = hold_q;
        nxt_timeout = 1'b0;

        // Search starts at the pointer so the last owner drops to lowest priority.
        win_found = 1'b0;
        win_id    = ptr_q;
        idx       = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!win_found && arb.req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end

        owner_req   = arb.req[gnt_id_q];
        hold_last   = (hold_q == HOLD_LAST);
        release_now = arb.done || !owner_req || hold_last;

        case (state)
            IDLE: begin
                if (win_found) begin
                    nxt_state  = GRANT;
                    nxt_gnt    = 4'b0001 << win_id;
                    nxt_gnt_id = win_id;
                    nxt_hold   = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    nxt_state   = IDLE;
                    nxt_gnt     = 4'b0000;
                    nxt_ptr     = gnt_id_q + 2'd1;
                    nxt_hold    = '0;
                    nxt_timeout = hold_last && !arb.done && owner_req;
                end else begin
                    nxt_hold = hold_q + CW'(1);
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        arb.gnt       = gnt_q;
        arb.gnt_id    = gnt_id_q;
        arb.gnt_valid = |gnt_q;
        arb.timeout   = timeout_q;
    end
endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: directed scenarios plus random traffic, all outputs
// compared every cycle against a client-level round-robin model.
module tb_rr_arbiter_4;
    localparam int MH = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    // model state: who owns the resource (-1 none), where the search starts, cycles held
    int   m_owner, m_ptr, m_hold, m_last_id, m_to;

    rr_arbiter_4_if bus ();

    rr_arbiter_4 #(.MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_hold = 0; m_last_id = 0; m_to = 0;
    endtask

    task automatic model_edge();
        bit rel_done, rel_drop, rel_lim;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_to = 0;
        if (m_owner < 0) begin
            for (int i = 0; i < 4; i++) begin
                int c;
                c = (m_ptr + i) % 4;
                if (bus.req[c]) begin
                    m_owner = c; m_last_id = c; m_hold = 0;
                    break;
                end
            end
        end else begin
            rel_done = bus.done;
            rel_drop = !bus.req[m_owner];
            rel_lim  = (m_hold == MH - 1);
            if (rel_done || rel_drop || rel_lim) begin
                m_to    = (rel_lim && !rel_done && !rel_drop) ? 1 : 0;
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_hold  = 0;
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic compare_outputs();
        int exp_gnt;
        exp_gnt = (m_owner < 0) ? 0 : (1 << m_owner);
        check("gnt", int'(bus.gnt), exp_gnt);
        check("gnt_valid", int'(bus.gnt_valid), (m_owner < 0) ? 0 : 1);
        check("timeout", int'(bus.timeout), m_to);
        if (m_owner >= 0) check("gnt_id", int'(bus.gnt_id), m_last_id);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req = 4'b1111;
        bus.done = 1'b0;
        model_reset();
        repeat (2) step();
        check("rst_gnt", int'(bus.gnt), 0);
        check("rst_valid", int'(bus.gnt_valid), 0);
        check("rst_timeout", int'(bus.timeout), 0);
        bus.req = 4'b0000;
        rst_n = 1'b1;
        repeat (3) step();
        check("idle_gnt", int'(bus.gnt), 0);
    endtask

    task automatic wait_grant(input string tag, input logic [3:0] exp);
        int n;
        n = 0;
        while (!bus.gnt_valid && n < 20) begin
            step();
            n++;
        end
        check(tag, int'(bus.gnt), int'(exp));
    endtask

    initial begin
        int seq [5] = '{1, 2, 4, 8, 1};
        int cnt;
        rst_n = 1'b0;
        bus.req = 4'b0000;
        bus.done = 1'b0;
        model_reset();
        #2;

        do_reset();

        // fixed start priority
        bus.req = 4'b1010;
        step();
        check("start_gnt", int'(bus.gnt), 2);
        check("start_id", int'(bus.gnt_id), 1);
        check("start_valid", int'(bus.gnt_valid), 1);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        check("start_gap", int'(bus.gnt), 0);
        step();
        check("start_next", int'(bus.gnt), 8);
        check("start_next_id", int'(bus.gnt_id), 3);

        // rotation
        do_reset();
        bus.req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            check("rot_gnt", int'(bus.gnt), seq[k]);
            bus.done = 1'b1;
            step();
            bus.done = 1'b0;
            check("rot_gap", int'(bus.gnt), 0);
            step();
        end

        // request drop by client 2
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req = 4'b0100;
        wait_grant("drop_grant", 4'b0100);
        bus.req = 4'b1011;
        step();
        check("drop_gnt", int'(bus.gnt), 0);
        check("drop_timeout", int'(bus.timeout), 0);
        step();
        check("drop_next", int'(bus.gnt), 8);

        // hold limit
        bus.req = 4'b0000;
        step(); step();
        bus.req = 4'b0001;
        wait_grant("to_grant", 4'b0001);
        cnt = 1;
        for (int i = 0; i < 20 && bus.gnt == 4'b0001; i++) begin
            step();
            if (bus.gnt == 4'b0001) cnt++;
        end
        check("to_hold_cycles", cnt, MH);
        check("to_pulse", int'(bus.timeout), 1);
        step();
        check("to_regrant", int'(bus.gnt), 1);
        check("to_pulse_end", int'(bus.timeout), 0);
        repeat (MH - 1) step();
        check("to_still_held", int'(bus.gnt), 1);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        check("to_done_gnt", int'(bus.gnt), 0);
        check("to_done_no_pulse", int'(bus.timeout), 0);

        // async reset mid-grant
        bus.req = 4'b0100;
        wait_grant("ar_grant", 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_gnt", int'(bus.gnt), 0);
        check("ar_valid", int'(bus.gnt_valid), 0);
        check("ar_timeout", int'(bus.timeout), 0);
        model_reset();
        bus.req = 4'b1111;
        #1;
        rst_n = 1'b1;
        step();
        check("ar_first", int'(bus.gnt), 1);

        // random traffic; requests change rarely so the hold limit is reached often
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) bus.req = 4'($urandom);
            bus.done = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
